// File: rtl/unary_add_n.sv
// Purpose : accumulate the popcount of N_IN unary inputs, then replay the total as a stream of 1s.
// Latency : one cycle from the sampled inputs to o_dout / o_c / o_done / o_count; o_empty is combinational.
// Backpr. : i_en=0 stalls the block; count, phase and o_dout hold, while o_c and o_done read 0.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_din[N_IN]      unary input bits; each set bit adds 1 while accumulating
//   i_en             cycle enable (0 = stall)
//   i_read_or_write  0 = accumulate phase, 1 = emit phase
//   i_clear          synchronous accumulator clear (takes effect whether or not i_en is set)
//   o_dout           registered unary output stream, one 1 per emitted count
//   o_c              registered overflow pulse (accumulate phase only)
//   o_done           registered pulse alongside the final emitted 1
//   o_count          accumulator register
//   o_empty          high while o_count == 0
//
// Build option: define UNARY_ADD_SAT_EN to saturate the accumulator at CMAX on overflow
// instead of wrapping. The overflow pulse is the same in both builds.

module unary_add_n #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IN-1:0]  i_din,
  input  logic             i_en,
  input  logic             i_read_or_write,
  input  logic             i_clear,
  output logic             o_dout,
  output logic             o_c,
  output logic             o_done,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_dout;
  logic             w_dout_nxt;
  logic             r_c;
  logic             w_c_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_sum;
  logic             w_ovf;

  // Popcount of the unary inputs. CNT_W >= clog2(N_IN+1), so CNT_W+1 bits always hold it.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_pop = w_pop + (CNT_W+1)'(i_din[i]);
    end
  end

  // One extra bit so the carry out of the accumulator is the overflow flag.
  assign w_sum = {1'b0, r_count} + w_pop;
  assign w_ovf = w_sum[CNT_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ACC;
      r_count <= '0;
      r_dout  <= 1'b0;
      r_c     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
      r_c     <= w_c_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // The phase acted on is the one sampled on i_read_or_write in the same cycle, so the first
  // emit-sampled edge already produces a 1. r_state therefore records the phase of the most
  // recent enabled cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dout_nxt  = r_dout;
    w_c_nxt     = 1'b0;
    w_done_nxt  = 1'b0;

    if (i_en) begin
      w_state_nxt = i_read_or_write ? ST_EMIT : ST_ACC;
      if (!i_read_or_write) begin
        w_dout_nxt = 1'b0;
        w_c_nxt    = w_ovf;
`ifdef UNARY_ADD_SAT_EN
        w_count_nxt = w_ovf ? CMAX : w_sum[CNT_W-1:0];
`else
        w_count_nxt = w_sum[CNT_W-1:0];
`endif
      end else if (r_count != '0) begin
        w_dout_nxt  = 1'b1;
        w_count_nxt = r_count - ONE;
        w_done_nxt  = (r_count == ONE);
      end else begin
        // An empty accumulator emits 0s and never underflows.
        w_dout_nxt = 1'b0;
      end
    end

    // Clear overrides the datapath. The phase register above still follows i_en.
    if (i_clear) begin
      w_count_nxt = '0;
      w_dout_nxt  = 1'b0;
      w_c_nxt     = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  assign o_dout  = r_dout;
  assign o_c     = r_c;
  assign o_done  = r_done;
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: tb/tb_unary_add_n.sv
module tb_unary_add_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'b0;
  logic       en = 1'b0;
  logic       rw = 1'b0;
  logic       clr = 1'b0;
  logic       dout, c, done, empty;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  // Behavioural reference state (integer arithmetic on the rules).
  int m_count = 0;
  int m_dout = 0;
  int m_c = 0;
  int m_done = 0;

`ifdef UNARY_ADD_SAT_EN
  localparam int OVF_CNT = 15;
  localparam bit SAT = 1'b1;
`else
  localparam int OVF_CNT = 2;
  localparam bit SAT = 1'b0;
`endif

  unary_add_n #(.N_IN(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_en(en), .i_read_or_write(rw), .i_clear(clr),
    .o_dout(dout), .o_c(c), .o_done(done), .o_count(count), .o_empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, rw, clr;
    logic [3:0] din;
    logic       dout, c, done;
    int         count;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic e, logic w, logic cl, logic [3:0] d,
                              logic eo, logic ec, logic ed, int ecnt);
    vec_t v;
    v.rst = r; v.en = e; v.rw = w; v.clr = cl; v.din = d;
    v.dout = eo; v.c = ec; v.done = ed; v.count = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_dout, input int e_c, input int e_done,
                         input int e_count);
    chk({tag, ".dout"}, int'(dout), e_dout);
    chk({tag, ".C"}, int'(c), e_c);
    chk({tag, ".done"}, int'(done), e_done);
    chk({tag, ".count"}, int'(count), e_count);
    chk({tag, ".empty"}, int'(empty), (e_count == 0) ? 1 : 0);
  endtask

  // Reference model: one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic e, input logic w, input logic cl,
                            input logic [3:0] d);
    int s;
    if (r) begin
      m_count = 0; m_dout = 0; m_c = 0; m_done = 0;
    end else if (cl) begin
      m_count = 0; m_dout = 0; m_c = 0; m_done = 0;
    end else if (!e) begin
      m_c = 0; m_done = 0;
    end else if (!w) begin
      s = m_count + $countones(d);
      m_c = (s > 15) ? 1 : 0;
      m_count = (s > 15) ? (SAT ? 15 : s - 16) : s;
      m_dout = 0; m_done = 0;
    end else begin
      m_c = 0;
      if (m_count > 0) begin
        m_dout = 1;
        m_done = (m_count == 1) ? 1 : 0;
        m_count = m_count - 1;
      end else begin
        m_dout = 0; m_done = 0;
      end
    end
  endtask

  // Apply inputs, take one rising edge, then settle outputs 1 time unit past the edge.
  task automatic step(input logic r, input logic e, input logic w, input logic cl,
                      input logic [3:0] d);
    rst = r; en = e; rw = w; clr = cl; din = d;
    @(posedge clk);
    #1;
    model_edge(r, e, w, cl, d);
  endtask

  initial begin
    // Reset, accumulate 3 x popcount(1011) = 9, emit 9 ones then a 0.
    vt.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 4'b1011, 0, 0, 0, 3));
    vt.push_back(mk(0, 1, 0, 0, 4'b1011, 0, 0, 0, 6));
    vt.push_back(mk(0, 1, 0, 0, 4'b1011, 0, 0, 0, 9));
    for (int k = 8; k >= 0; k--)
      vt.push_back(mk(0, 1, 1, 0, 4'b0000, 1, 0, (k == 0) ? 1'b1 : 1'b0, k));
    vt.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0));
    // Accumulate to 14, then add 4 more: overflow pulse for one cycle.
    vt.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 0, 0, 4));
    vt.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 0, 0, 8));
    vt.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 0, 0, 12));
    vt.push_back(mk(0, 1, 0, 0, 4'b0011, 0, 0, 0, 14));
    vt.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 1, 0, OVF_CNT));
    vt.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0, OVF_CNT));

    @(negedge clk);
    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].en, vt[i].rw, vt[i].clr, vt[i].din);
      chk_all($sformatf("vec%0d", i), vt[i].dout, vt[i].c, vt[i].done, vt[i].count);
    end

    // Stall mid-emit: count 5, two 1s out, en low 3 cycles, then the remaining three 1s.
    step(1, 0, 0, 0, 4'b0000);
    step(0, 1, 0, 0, 4'b1111);
    step(0, 1, 0, 0, 4'b0001);
    chk_all("stall.acc", 0, 0, 0, 5);
    step(0, 1, 1, 0, 4'b0000);
    step(0, 1, 1, 0, 4'b0000);
    chk_all("stall.second1", 1, 0, 0, 3);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0, 4'b0000);
      chk_all($sformatf("stall.hold%0d", k), 1, 0, 0, 3);
    end
    for (int k = 2; k >= 0; k--) begin
      step(0, 1, 1, 0, 4'b0000);
      chk_all($sformatf("stall.resume%0d", k), 1, 0, (k == 0) ? 1 : 0, k);
    end
    step(0, 1, 1, 0, 4'b0000);
    chk_all("stall.after", 0, 0, 0, 0);

    // Clear together with the first emit cycle: nothing is emitted and done never fires.
    step(0, 1, 0, 0, 4'b1111);
    step(0, 1, 0, 0, 4'b0111);
    chk_all("clr.acc", 0, 0, 0, 7);
    step(0, 1, 1, 1, 4'b0000);
    chk_all("clr.edge", 0, 0, 0, 0);
    step(0, 1, 1, 0, 4'b0000);
    chk_all("clr.after", 0, 0, 0, 0);

    // Clear wins even while stalled.
    step(0, 1, 0, 0, 4'b0011);
    step(0, 0, 0, 1, 4'b1111);
    chk_all("clr.stalled", 0, 0, 0, 0);

    // Reset mid-emit abandons the stream; the next enabled edge accumulates normally.
    step(0, 1, 0, 0, 4'b1111);
    step(0, 1, 0, 0, 4'b0011);
    step(0, 1, 1, 0, 4'b0000);
    step(0, 1, 1, 0, 4'b0000);
    chk_all("rst.mid", 1, 0, 0, 4);
    step(1, 1, 1, 0, 4'b0000);
    chk_all("rst.edge", 0, 0, 0, 0);
    step(0, 1, 0, 0, 4'b0001);
    chk_all("rst.after", 0, 0, 0, 1);

    // Randomised run against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic r, e, w, cl;
      logic [3:0] d;
      r  = ($urandom_range(0, 59) == 0);
      cl = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      w  = ((k / 12) % 2 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      d  = 4'($urandom);
      step(r, e, w, cl, d);
      chk_all($sformatf("rnd%0d", k), m_dout, m_c, m_done, m_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
